icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. Serves the fetch stage's combinational word request (`nd_ins`/`pc_fetch`) with a one-cycle `flg_get` pulse carrying the instruction word. On a miss it fetches the word from the memory controller over a request/done handshake, fills the line, then delivers. A fetch-stage redirect (`flush`) cancels delivery of any outstanding word.

## Interface
- `IDX_W`, default 8: index bits; the cache has 2^IDX_W one-word lines.
- `TAG_W`, default 32-2-IDX_W: tag bits, derived and not overridable.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global ready; when low, all state, including outputs, holds.
- `nd_ins` input 1: fetch stage requests a word; combinational, level.
- `pc_fetch` input 32: byte address of requested word; bits [1:0] ignored.
- `flush` input 1: fetch redirect (jal_reset); drops any pending delivery.
- `flg_get` output 1: one-cycle pulse, `ins_out` valid.
- `ins_out` output 32: instruction word.
- `mem_req` output 1: word read request to memory controller; level, held until done.
- `mem_addr` output 32: word-aligned request address; stable while `mem_req`.
- `mem_done` input 1: one-cycle pulse, `mem_data` valid.
- `mem_data` input 32: fetched word.

## Operation
- Address split: offset [1:0], index [IDX_W+1:2], tag [31:IDX_W+2].
- Per-line storage: valid bit, TAG_W tag, 32-bit data.
- Hit condition: `valid[idx] && tag[idx]==pc_fetch tag`.
- FSM states:
  - IDLE
    - flush: stay.
    - nd_ins & hit: register data, pulse flg_get, go RESP.
    - nd_ins & miss: latch address, go MISS.
  - RESP: one-cycle cooldown; flg_get deasserted, nd_ins ignored; return to IDLE. This lets the fetch stage drop nd_ins.
  - MISS: mem_req=1, mem_addr = latched address with [1:0]=0.
    - mem_done: write valid/tag/data at the latched index.
    - If no flush was seen during MISS: drive ins_out=mem_data, pulse flg_get, go RESP.
    - Otherwise go IDLE with no pulse.
    - flush while waiting: set sticky `drop` flag; the memory transaction is never aborted and the line is still filled.
- flush in the same cycle as a hit: no pulse, stay IDLE.
- flush in the same cycle as mem_done: line filled, no pulse.
- Conflicting index: the line is overwritten; there is no write-back because the cache is read-only.
- No self-modifying-code coherence; stores never invalidate lines.

## Timing
- Reset values: flg_get=0, ins_out=0, mem_req=0, mem_addr=0, state=IDLE, drop=0, all valid=0.
- rst mid-miss: request abandoned immediately; the memory controller resets on the same edge.
- Hit latency: nd_ins sampled at edge t; flg_get high for cycle t+1 only.
- Miss: mem_req rises cycle t+1. mem_done in cycle m leads to the line written at edge m, flg_get high in cycle m+1. Minimum miss latency is 2 cycles plus memory latency.
- Back-to-back hits: one delivery per 2 cycles, because of the RESP cooldown.
- rdy low: no state change; registered outputs hold. mem_done arriving while rdy low is illegal; the memory controller is also stalled by rdy.
- All outputs are registered; no combinational path from nd_ins/pc_fetch to any output.

## Structure
- Shared `def.v`: `HIGH`/`LOW`, `ICACHE_IDX_W` default, FSM state encodings `IC_IDLE`/`IC_RESP`/`IC_MISS`.
- Sub-module `icache_array`:
  - valid/tag/data storage.
  - Combinational read port: index → valid, tag, data.
  - One synchronous write port.
  - Valid bits cleared on rst.
- FSM and handshake logic live in `icache`.

## Test plan
- Cold miss: after reset, nd_ins=1, pc_fetch=0x0000_0004. Required: mem_req=1, mem_addr=0x4. Reply mem_done with 0x0000_0013 after 3 cycles; flg_get pulses for exactly 1 cycle the following cycle with ins_out=0x13.
- Hit: after the cold miss, request pc 0x4 again. Required: flg_get on the next cycle, ins_out=0x13, mem_req stays 0.
- Conflict: fill pc 0x4, then request pc 0x404 (same index, IDX_W=8). Required: miss, mem_addr=0x404. Then request pc 0x4: miss again.
- Flush mid-miss: request pc 0x8, assert flush while mem_req=1. mem_done data=0x6F. Required: no flg_get. A later request to pc 0x8 hits with 0x6F.
- rdy stall: hold rdy=0 for 4 cycles after a hit request is sampled. Required: flg_get stays high through the stall and drops one enabled cycle after rdy returns; no duplicate pulse.
- Reset mid-miss: assert rst while mem_req=1. Required: mem_req=0 next cycle, and a subsequent request to the same pc misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: logic levels, default geometry,
// FSM state encodings and a word-alignment helper.
package icache_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int ICACHE_IDX_W = 8;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_RESP = 2'd1,
    IC_MISS = 2'd2
  } ic_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational read port,
// one synchronous write port. Only the valid bits are reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= HIGH;
    end
  end

  // Tag/data need no reset: a line is never consulted while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between fetch and the memory controller.
// All outputs are registered; a redirect (flush) suppresses any outstanding delivery.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        nd_ins,
  input  logic [31:0] pc_fetch,
  input  logic        flush,
  output logic        flg_get,
  output logic [31:0] ins_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int TAG_W = 30 - IDX_W;

  ic_state_e   state_q, state_d;
  logic        drop_q, drop_d;
  logic        flg_get_q, flg_get_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             fill_we;

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pc_fetch[IDX_W+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (mem_addr_q[IDX_W+1:2]),
    .wr_tag_i   (mem_addr_q[31:IDX_W+2]),
    .wr_data_i  (mem_data)
  );

  assign hit = rd_valid && (rd_tag == pc_fetch[31:IDX_W+2]);

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    flg_get_d  = LOW;
    ins_out_d  = ins_out_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_we    = LOW;
    case (state_q)
      IC_IDLE: begin
        if (flush) begin
          state_d = IC_IDLE;
        end else if (nd_ins && hit) begin
          ins_out_d = rd_data;
          flg_get_d = HIGH;
          state_d   = IC_RESP;
        end else if (nd_ins) begin
          mem_addr_d = word_align(pc_fetch);
          mem_req_d  = HIGH;
          drop_d     = LOW;
          state_d    = IC_MISS;
        end
      end
      IC_RESP: begin
        state_d = IC_IDLE;
      end
      IC_MISS: begin
        if (mem_done) begin
          // The fill always completes; only the delivery is subject to a redirect.
          fill_we   = rdy;
          mem_req_d = LOW;
          drop_d    = LOW;
          if (!drop_q && !flush) begin
            ins_out_d = mem_data;
            flg_get_d = HIGH;
            state_d   = IC_RESP;
          end else begin
            state_d = IC_IDLE;
          end
        end else if (flush) begin
          drop_d = HIGH;
        end
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IC_IDLE;
      drop_q     <= LOW;
      flg_get_q  <= LOW;
      ins_out_q  <= '0;
      mem_req_q  <= LOW;
      mem_addr_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      flg_get_q  <= flg_get_d;
      ins_out_q  <= ins_out_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign flg_get  = flg_get_q;
  assign ins_out  = ins_out_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written stall/reset
// sequences, then randomized fetches checked against a line-level reference model.
module tb_icache;

  localparam int IDX_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        nd_ins;
  logic [31:0] pc_fetch;
  logic        flush;
  logic        flg_get;
  logic [31:0] ins_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: line index -> word address held, and its data.
  logic [31:0] line_addr [int];
  logic [31:0] line_data [int];

  always #5 clk = ~clk;

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .nd_ins   (nd_ins),
    .pc_fetch (pc_fetch),
    .flush    (flush),
    .flg_get  (flg_get),
    .ins_out  (ins_out),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_done (mem_done),
    .mem_data (mem_data)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    int          lat;
    bit          fl_mid;
    bit          fl_done;
    bit          hit;
    bit          flg;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [31:0] pc, input int lat,
                              input bit fl_mid, input bit fl_done, input bit hit,
                              input bit flg, input logic [31:0] data);
    vec_t v;
    v.nm = nm; v.pc = pc; v.lat = lat; v.fl_mid = fl_mid; v.fl_done = fl_done;
    v.hit = hit; v.flg = flg; v.data = data;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    logic [31:0] wa;
    wa = pc & 32'hFFFF_FFFC;
    return line_addr.exists(idx_of(pc)) && line_addr[idx_of(pc)] == wa;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One complete fetch. For hits, fl_done means flush in the same cycle as the request.
  task automatic run_fetch(input string nm, input logic [31:0] pc, input int lat,
                           input bit fl_mid, input bit fl_done, input bit exp_hit,
                           input bit exp_flg, input logic [31:0] data);
    nd_ins   = 1'b1;
    pc_fetch = pc;
    if (exp_hit) begin
      flush = fl_done;
      step();
      flush  = 1'b0;
      nd_ins = 1'b0;
      chk({nm, ".flg"}, 32'(flg_get), 32'(exp_flg));
      if (exp_flg) chk({nm, ".data"}, ins_out, data);
      chk({nm, ".noreq"}, 32'(mem_req), 32'd0);
      step();
      chk({nm, ".cool"}, 32'(flg_get), 32'd0);
    end else begin
      step();
      chk({nm, ".req"}, 32'(mem_req), 32'd1);
      chk({nm, ".addr"}, mem_addr, pc & 32'hFFFF_FFFC);
      chk({nm, ".nopulse"}, 32'(flg_get), 32'd0);
      for (int i = 0; i < lat; i++) begin
        flush = fl_mid && (i == 0);
        step();
        flush = 1'b0;
        chk({nm, ".hold"}, 32'(mem_req), 32'd1);
      end
      mem_done = 1'b1;
      mem_data = data;
      flush    = fl_done;
      step();
      mem_done = 1'b0;
      flush    = 1'b0;
      nd_ins   = 1'b0;
      line_addr[idx_of(pc)] = pc & 32'hFFFF_FFFC;
      line_data[idx_of(pc)] = data;
      chk({nm, ".flg"}, 32'(flg_get), 32'(exp_flg));
      if (exp_flg) chk({nm, ".data"}, ins_out, data);
      chk({nm, ".reqdrop"}, 32'(mem_req), 32'd0);
      step();
      chk({nm, ".cool"}, 32'(flg_get), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] tags [4];
    logic [31:0] pc;
    bit          h, fm, fd;
    int          lat;

    rst = 1'b1; rdy = 1'b1; nd_ins = 1'b0; pc_fetch = '0; flush = 1'b0;
    mem_done = 1'b0; mem_data = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst.flg", 32'(flg_get), 32'd0);
    chk("rst.ins", ins_out, 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);

    vecs.push_back(mk("cold",        32'h0000_0004, 3, 0, 0, 0, 1, 32'h0000_0013));
    vecs.push_back(mk("hit",         32'h0000_0004, 0, 0, 0, 1, 1, 32'h0000_0013));
    vecs.push_back(mk("conflict",    32'h0000_0404, 2, 0, 0, 0, 1, 32'h0000_00AB));
    vecs.push_back(mk("reconflict",  32'h0000_0004, 1, 0, 0, 0, 1, 32'h0000_0013));
    vecs.push_back(mk("hit_flush",   32'h0000_0004, 0, 0, 1, 1, 0, 32'h0000_0013));
    vecs.push_back(mk("hit_again",   32'h0000_0004, 0, 0, 0, 1, 1, 32'h0000_0013));
    vecs.push_back(mk("flush_mid",   32'h0000_0008, 2, 1, 0, 0, 0, 32'h0000_006F));
    vecs.push_back(mk("after_flush", 32'h0000_0008, 0, 0, 0, 1, 1, 32'h0000_006F));
    vecs.push_back(mk("offset",      32'h0000_000B, 0, 0, 0, 1, 1, 32'h0000_006F));
    vecs.push_back(mk("flush_done",  32'h0000_0010, 1, 0, 1, 0, 0, 32'h0000_1234));
    vecs.push_back(mk("after_fdone", 32'h0000_0010, 0, 0, 0, 1, 1, 32'h0000_1234));
    vecs.push_back(mk("top_miss",    32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk("top_hit",     32'hFFFF_FFFF, 0, 0, 0, 1, 1, 32'hDEAD_BEEF));

    foreach (vecs[i])
      run_fetch(vecs[i].nm, vecs[i].pc, vecs[i].lat, vecs[i].fl_mid, vecs[i].fl_done,
                vecs[i].hit, vecs[i].flg, vecs[i].data);

    // Flush alongside a missing request: no memory request is issued.
    nd_ins = 1'b1; pc_fetch = 32'h0000_0030; flush = 1'b1;
    step();
    nd_ins = 1'b0; flush = 1'b0;
    chk("idle_flush.req", 32'(mem_req), 32'd0);
    chk("idle_flush.flg", 32'(flg_get), 32'd0);

    // rdy stall right after a hit is sampled: the pulse is held, then drops once.
    nd_ins = 1'b1; pc_fetch = 32'h0000_0008;
    step();
    nd_ins = 1'b0;
    rdy = 1'b0;
    chk("stall.flg0", 32'(flg_get), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall.hold", 32'(flg_get), 32'd1);
      chk("stall.data", ins_out, 32'h0000_006F);
    end
    rdy = 1'b1;
    step();
    chk("stall.drop", 32'(flg_get), 32'd0);
    step();
    chk("stall.nodup", 32'(flg_get), 32'd0);

    // Reset while a miss is outstanding.
    nd_ins = 1'b1; pc_fetch = 32'h0000_0020;
    step();
    chk("rstmiss.req", 32'(mem_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; nd_ins = 1'b0;
    chk("rstmiss.reqdrop", 32'(mem_req), 32'd0);
    chk("rstmiss.flg", 32'(flg_get), 32'd0);
    line_addr.delete();
    line_data.delete();
    run_fetch("rstmiss.refetch", 32'h0000_0020, 2, 0, 0, 0, 1, 32'h0000_0777);
    run_fetch("rstmiss.cleared", 32'h0000_0004, 1, 0, 0, 0, 1, 32'h0000_0013);

    // Randomized fetches over a few aliasing tags against the line-level model.
    tags[0] = 32'h0000_0000; tags[1] = 32'h0000_0400;
    tags[2] = 32'h0001_0000; tags[3] = 32'h8000_0000;
    for (int n = 0; n < 200; n++) begin
      pc  = tags[$urandom_range(3)] + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
      lat = $urandom_range(4);
      fm  = (lat > 0) && ($urandom_range(5) == 0);
      fd  = ($urandom_range(7) == 0);
      h   = model_hit(pc);
      if (h)
        run_fetch("rnd_hit", pc, 0, 0, fd, 1, !fd, line_data[idx_of(pc)]);
      else
        run_fetch("rnd_miss", pc, lat, fm, fd, 0, !(fm || fd), mem_word(pc & 32'hFFFF_FFFC));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
